shapool_sequencer: RTL and testbench

Job sequencer for the shapool hashing pool. It takes a freshly loaded job and a starting nonce and launches the POOL_SIZE hash cores one batch at a time. Between batches it advances the nonce base, and it stops on the first core to meet the target or when the nonce space is exhausted. It sits in `top` between the SPI job-load logic and the core pool, and it drives the READY flag path.

---
 rtl/shapool_sequencer.sv | 117 +++++++++++
 tb/tb_shapool_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shapool_sequencer.sv
// Job sequencer for the shapool hashing pool: launches POOL_SIZE-wide nonce batches,
// advances the base between batches and reports the first winner, exhaustion or a watchdog fault.
module shapool_sequencer #(
  parameter int POOL_SIZE       = 2,
  parameter int POOL_SIZE_LOG2  = 1,
  parameter int NONCE_WIDTH     = 32,
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic                      job_valid_in,
  input  logic                      halt_in,
  input  logic [NONCE_WIDTH-1:0]    nonce_start_in,
  input  logic                      hash_done_in,
  input  logic [POOL_SIZE-1:0]      success_in,
  output logic                      pool_start_out,
  output logic [NONCE_WIDTH-1:0]    nonce_out,
  output logic                      busy_out,
  output logic                      ready_n_out,
  output logic                      found_out,
  output logic                      fault_out,
  output logic [POOL_SIZE_LOG2-1:0] winner_idx_out,
  output logic [NONCE_WIDTH-1:0]    winner_nonce_out
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam int NW1  = NONCE_WIDTH + 1;
  localparam logic [NONCE_WIDTH-1:0] LOW_MASK = NONCE_WIDTH'(POOL_SIZE - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, FOUND, EXHAUSTED} state_t;

  state_t                    state;
  logic [WD_W-1:0]           wd_cnt;
  logic [POOL_SIZE_LOG2-1:0] win_idx;
  logic                      any_win;
  logic [NONCE_WIDTH:0]      next_base;

  // Lowest-index winner takes priority when several cores hit together.
  always_comb begin
    win_idx = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--)
      if (success_in[i]) win_idx = POOL_SIZE_LOG2'(i);
  end

  assign any_win   = |success_in;
  // Extra top bit is the carry that marks the end of the nonce space.
  assign next_base = {1'b0, nonce_out} + NW1'(POOL_SIZE);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state            <= IDLE;
      wd_cnt           <= '0;
      pool_start_out   <= 1'b0;
      nonce_out        <= '0;
      busy_out         <= 1'b0;
      ready_n_out      <= 1'b1;
      found_out        <= 1'b0;
      fault_out        <= 1'b0;
      winner_idx_out   <= '0;
      winner_nonce_out <= '0;
    end else if (halt_in) begin
      state          <= IDLE;
      pool_start_out <= 1'b0;
      busy_out       <= 1'b0;
      ready_n_out    <= 1'b1;
    end else if (job_valid_in) begin
      // New job from any state; an in-flight batch result is dropped.
      state          <= START;
      wd_cnt         <= '0;
      pool_start_out <= 1'b1;
      nonce_out      <= nonce_start_in & ~LOW_MASK;
      busy_out       <= 1'b1;
      ready_n_out    <= 1'b1;
      found_out      <= 1'b0;
      fault_out      <= 1'b0;
    end else begin
      case (state)
        START: begin
          state          <= WAIT;
          pool_start_out <= 1'b0;
          wd_cnt         <= '0;
        end
        WAIT: begin
          if (hash_done_in) begin
            if (any_win) begin
              state            <= FOUND;
              busy_out         <= 1'b0;
              ready_n_out      <= 1'b0;
              found_out        <= 1'b1;
              winner_idx_out   <= win_idx;
              winner_nonce_out <= nonce_out | NONCE_WIDTH'(win_idx);
            end else if (next_base[NONCE_WIDTH]) begin
              state       <= EXHAUSTED;
              busy_out    <= 1'b0;
              ready_n_out <= 1'b0;
              found_out   <= 1'b0;
            end else begin
              state          <= START;
              nonce_out      <= next_base[NONCE_WIDTH-1:0];
              pool_start_out <= 1'b1;
            end
          end else if (wd_cnt == WD_W'(WATCHDOG_CYCLES)) begin
            state       <= EXHAUSTED;
            busy_out    <= 1'b0;
            ready_n_out <= 1'b0;
            found_out   <= 1'b0;
            fault_out   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shapool_sequencer.sv
// Randomized self-checking bench for shapool_sequencer; expectations come from a
// job-level model (base arithmetic, lowest-set-bit winner, watchdog cycle count).
module tb_shapool_sequencer;
  localparam int POOL = 2;
  localparam int LOG2 = 1;
  localparam int NW   = 32;
  localparam int WD   = 255;

  logic            clk_in = 1'b0;
  logic            reset_n_in = 1'b0;
  logic            job_valid_in = 1'b0;
  logic            halt_in = 1'b0;
  logic [NW-1:0]   nonce_start_in = '0;
  logic            hash_done_in = 1'b0;
  logic [POOL-1:0] success_in = '0;
  logic            pool_start_out;
  logic [NW-1:0]   nonce_out;
  logic            busy_out;
  logic            ready_n_out;
  logic            found_out;
  logic            fault_out;
  logic [LOG2-1:0] winner_idx_out;
  logic [NW-1:0]   winner_nonce_out;

  int n_chk = 0;
  int n_fail = 0;

  // job-level model state
  logic [NW-1:0]   m_base = '0;
  logic [NW-1:0]   m_wnonce = '0;
  logic [LOG2-1:0] m_widx = '0;
  logic            m_fault = 1'b0;

  always #5 clk_in = ~clk_in;

  shapool_sequencer #(
    .POOL_SIZE(POOL), .POOL_SIZE_LOG2(LOG2), .NONCE_WIDTH(NW), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .job_valid_in(job_valid_in),
    .halt_in(halt_in), .nonce_start_in(nonce_start_in), .hash_done_in(hash_done_in),
    .success_in(success_in), .pool_start_out(pool_start_out), .nonce_out(nonce_out),
    .busy_out(busy_out), .ready_n_out(ready_n_out), .found_out(found_out),
    .fault_out(fault_out), .winner_idx_out(winner_idx_out),
    .winner_nonce_out(winner_nonce_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ps, input logic bsy,
                         input logic rdy_n, input logic fnd);
    chk({tag, ".pool_start"}, 64'(pool_start_out), 64'(ps));
    chk({tag, ".busy"}, 64'(busy_out), 64'(bsy));
    chk({tag, ".ready_n"}, 64'(ready_n_out), 64'(rdy_n));
    chk({tag, ".found"}, 64'(found_out), 64'(fnd));
    chk({tag, ".fault"}, 64'(fault_out), 64'(m_fault));
    chk({tag, ".nonce"}, 64'(nonce_out), 64'(m_base));
    chk({tag, ".win_idx"}, 64'(winner_idx_out), 64'(m_widx));
    chk({tag, ".win_nonce"}, 64'(winner_nonce_out), 64'(m_wnonce));
  endtask

  task automatic job_begin(input logic [NW-1:0] ns);
    job_valid_in = 1'b1;
    nonce_start_in = ns;
    tick();
    job_valid_in = 1'b0;
    m_base = ns - (ns % POOL);
    m_fault = 1'b0;
    chk_all("job", 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // One batch: enter WAIT, idle `delay` cycles, then report done with `succ`.
  task automatic batch(input logic [POOL-1:0] succ, input int delay, output bit ended);
    bit got;
    tick();
    chk_all("wait", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (delay) tick();
    hash_done_in = 1'b1;
    success_in = succ;
    tick();
    hash_done_in = 1'b0;
    success_in = '0;
    if (succ != 0) begin
      got = 1'b0;
      for (int i = 0; i < POOL; i++)
        if (succ[i] && !got) begin
          got = 1'b1;
          m_widx = LOG2'(i);
        end
      m_wnonce = m_base + NW'(m_widx);
      chk_all("found", 1'b0, 1'b0, 1'b0, 1'b1);
      ended = 1'b1;
    end else if (longint'(m_base) + POOL > 64'h0000_0000_FFFF_FFFF) begin
      chk_all("exhaust", 1'b0, 1'b0, 1'b0, 1'b0);
      ended = 1'b1;
    end else begin
      m_base = m_base + NW'(POOL);
      chk_all("next", 1'b1, 1'b1, 1'b1, 1'b0);
      ended = 1'b0;
    end
  endtask

  initial begin
    bit ended;
    int cnt;
    logic [NW-1:0] ns;
    logic [POOL-1:0] succ;

    // reset values
    repeat (2) tick();
    chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // found on first batch
    job_begin(32'h0000_1003);
    batch(2'b10, 2, ended);

    // multi-batch: 0,2,4,6 then a winner
    job_begin(32'h0);
    for (int k = 0; k < 3; k++) batch(2'b00, k, ended);
    batch(2'b01, 0, ended);

    // exhaustion, and no further launches
    job_begin(32'hFFFF_FFFE);
    batch(2'b00, 1, ended);
    repeat (3) begin
      tick();
      chk_all("exh_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // simultaneous winners pick the lowest index
    job_begin(32'h1234_5679);
    batch(2'b11, 3, ended);

    // watchdog: START, then WAIT with counter 0..WD, fault visible after that
    job_begin(32'hABCD_0000);
    cnt = 0;
    while (ready_n_out === 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("wd.cycles", 64'(cnt), 64'(WD + 2));
    m_fault = 1'b1;
    chk_all("wd", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort: job_valid wins over a same-cycle winning done
    job_begin(32'h0000_0100);
    tick();
    repeat (3) tick();
    job_valid_in = 1'b1;
    nonce_start_in = 32'h0000_0555;
    hash_done_in = 1'b1;
    success_in = 2'b01;
    tick();
    job_valid_in = 1'b0;
    hash_done_in = 1'b0;
    success_in = '0;
    m_base = 32'h0000_0554;
    chk_all("abort", 1'b1, 1'b1, 1'b1, 1'b0);
    batch(2'b10, 0, ended);

    // halt during WAIT; a late done is ignored in IDLE
    job_begin(32'h0000_2000);
    repeat (2) tick();
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk_all("halt", 1'b0, 1'b0, 1'b1, 1'b0);
    hash_done_in = 1'b1;
    success_in = 2'b01;
    tick();
    hash_done_in = 1'b0;
    success_in = '0;
    chk_all("halt_ign", 1'b0, 1'b0, 1'b1, 1'b0);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      case ($urandom_range(0, 3))
        0:       ns = 32'hFFFF_FFF8 | NW'($urandom_range(0, 7));
        1:       ns = NW'($urandom_range(0, 15));
        default: ns = $urandom;
      endcase
      job_begin(ns);
      ended = 1'b0;
      for (int k = 0; !ended; k++) begin
        if (k >= 5) succ = POOL'($urandom_range(1, 3));
        else if ($urandom_range(0, 3) == 0) succ = POOL'($urandom_range(0, 3));
        else succ = '0;
        batch(succ, $urandom_range(0, 12), ended);
      end
      if ($urandom_range(0, 4) == 0) begin
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        chk_all("rnd_halt", 1'b0, 1'b0, 1'b1, found_out);
      end
    end

    // asynchronous reset mid-batch
    job_begin(32'h0000_4000);
    tick();
    #2 reset_n_in = 1'b0;
    #1;
    m_base = '0;
    m_widx = '0;
    m_wnonce = '0;
    m_fault = 1'b0;
    chk_all("rst_async", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("rst_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    tick();
    chk_all("rst_rel", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
